// File: rtl/input_vector_streamer.sv
// Captures a packed input vector and its label, then streams the elements one per
// cycle over valid/ready, optionally repeating the whole vector num_passes times.
module input_vector_streamer #(
  parameter int datawidth           = 11,
  parameter int input_vector_length = 64,
  parameter int label_classes       = 10,
  parameter int num_passes          = 1
) (
  input  logic                                     clk,
  input  logic                                     rst_overall,
  input  logic                                     rst_vals,
  input  logic [datawidth*input_vector_length-1:0] input_values,
  input  logic [$clog2(label_classes)-1:0]         label_in,
  input  logic                                     input_loaded,
  output logic signed [datawidth-1:0]              elem_data,
  output logic                                     elem_valid,
  input  logic                                     elem_ready,
  output logic [$clog2(input_vector_length)-1:0]   elem_index,
  output logic                                     elem_last,
  output logic [$clog2(num_passes):0]              pass_index,
  output logic [$clog2(label_classes)-1:0]         label_out,
  output logic                                     vector_done,
  output logic                                     busy,
  output logic                                     overrun_err
);

  localparam int IW = $clog2(input_vector_length);
  localparam int LW = $clog2(label_classes);
  localparam int PW = $clog2(num_passes) + 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(input_vector_length - 1);
  localparam logic [PW-1:0] LAST_PASS = PW'(num_passes - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t state_q, state_d;

  logic [datawidth-1:0] buffer_q [input_vector_length];
  logic [IW-1:0]        idx_q;
  logic [PW-1:0]        pass_q;
  logic [LW-1:0]        label_q;
  logic                 done_q;
  logic                 overrun_q;

  logic capture, xfer, at_last, final_xfer;

  always_comb begin
    capture    = input_loaded && (state_q == IDLE);
    at_last    = (idx_q == LAST_IDX);
    xfer       = (state_q == STREAM) && elem_ready;
    final_xfer = xfer && at_last && (pass_q == LAST_PASS);
    state_d    = state_q;
    case (state_q)
      IDLE:    if (capture)    state_d = STREAM;
      STREAM:  if (final_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_overall) begin
    if (rst_overall)   state_q <= IDLE;
    else if (rst_vals) state_q <= IDLE;
    else               state_q <= state_d;
  end

  // Counters wrap to the next pass on the last element without a bubble; they
  // park at their final values after the last pass until the next capture.
  always_ff @(posedge clk or posedge rst_overall) begin
    if (rst_overall) begin
      for (int i = 0; i < input_vector_length; i++) buffer_q[i] <= '0;
      idx_q     <= '0;
      pass_q    <= '0;
      label_q   <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else if (rst_vals) begin
      for (int i = 0; i < input_vector_length; i++) buffer_q[i] <= '0;
      idx_q     <= '0;
      pass_q    <= '0;
      label_q   <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q <= final_xfer;
      if (input_loaded && (state_q == STREAM)) overrun_q <= 1'b1;
      if (capture) begin
        for (int i = 0; i < input_vector_length; i++)
          buffer_q[i] <= input_values[i*datawidth +: datawidth];
        label_q <= label_in;
        idx_q   <= '0;
        pass_q  <= '0;
      end else if (xfer) begin
        if (!at_last) begin
          idx_q <= idx_q + 1'b1;
        end else if (pass_q != LAST_PASS) begin
          idx_q  <= '0;
          pass_q <= pass_q + 1'b1;
        end
      end
    end
  end

  assign elem_valid  = (state_q == STREAM);
  assign busy        = (state_q == STREAM);
  assign elem_data   = buffer_q[idx_q];
  assign elem_last   = (state_q == STREAM) && at_last;
  assign elem_index  = idx_q;
  assign pass_index  = pass_q;
  assign label_out   = label_q;
  assign vector_done = done_q;
  assign overrun_err = overrun_q;

endmodule

// File: tb/tb_input_vector_streamer.sv
// Self-checking bench: a single-pass and a three-pass streamer checked against a
// transfer-list model built directly from the captured vector.
module tb_input_vector_streamer;

  localparam int DW = 11;
  localparam int N  = 64;
  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            rst_overall, rst_vals;
  logic [DW*N-1:0] input_values;
  logic [LW-1:0]   label_in;
  logic            load1, load3, elem_ready;

  logic signed [DW-1:0] d1_data, d3_data;
  logic                 d1_valid, d3_valid, d1_last, d3_last;
  logic [5:0]           d1_index, d3_index;
  logic [0:0]           d1_pass;
  logic [2:0]           d3_pass;
  logic [LW-1:0]        d1_label, d3_label;
  logic                 d1_done, d3_done, d1_busy, d3_busy, d1_ovr, d3_ovr;

  input_vector_streamer #(.num_passes(1)) dut1 (
    .clk(clk), .rst_overall(rst_overall), .rst_vals(rst_vals),
    .input_values(input_values), .label_in(label_in), .input_loaded(load1),
    .elem_data(d1_data), .elem_valid(d1_valid), .elem_ready(elem_ready),
    .elem_index(d1_index), .elem_last(d1_last), .pass_index(d1_pass),
    .label_out(d1_label), .vector_done(d1_done), .busy(d1_busy),
    .overrun_err(d1_ovr));

  input_vector_streamer #(.num_passes(3)) dut3 (
    .clk(clk), .rst_overall(rst_overall), .rst_vals(rst_vals),
    .input_values(input_values), .label_in(label_in), .input_loaded(load3),
    .elem_data(d3_data), .elem_valid(d3_valid), .elem_ready(elem_ready),
    .elem_index(d3_index), .elem_last(d3_last), .pass_index(d3_pass),
    .label_out(d3_label), .vector_done(d3_done), .busy(d3_busy),
    .overrun_err(d3_ovr));

  always #5 clk = ~clk;

  bit                   sel3 = 1'b0;
  logic signed [DW-1:0] s_data;
  logic                 s_valid, s_last, s_done, s_busy, s_ovr;
  logic [5:0]           s_index;
  logic [2:0]           s_pass;
  logic [LW-1:0]        s_label;

  assign s_data  = sel3 ? d3_data  : d1_data;
  assign s_valid = sel3 ? d3_valid : d1_valid;
  assign s_last  = sel3 ? d3_last  : d1_last;
  assign s_done  = sel3 ? d3_done  : d1_done;
  assign s_busy  = sel3 ? d3_busy  : d1_busy;
  assign s_ovr   = sel3 ? d3_ovr   : d1_ovr;
  assign s_index = sel3 ? d3_index : d1_index;
  assign s_pass  = sel3 ? d3_pass  : {2'b00, d1_pass};
  assign s_label = sel3 ? d3_label : d1_label;

  typedef struct {
    logic signed [DW-1:0] data;
    int                   idx;
    bit                   last;
    int                   pass;
  } xfer_t;

  typedef struct {
    int          mode;
    bit          use3;
    int          passes;
    logic [3:0]  label;
    int          pattern;
    int          exp_xfers;
    int          exp_lasts;
    int          exp_final_pass;
  } row_t;

  logic signed [DW-1:0] cur_vec [N];
  xfer_t                exp_q [$];
  int                   n_checks = 0;
  int                   n_pass   = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fill_vec(input int pattern);
    for (int i = 0; i < N; i++)
      cur_vec[i] = (pattern == 0) ? DW'(i - 32) : DW'($urandom);
  endtask

  // Drives one capture pulse starting at a negedge; returns one cycle later.
  task automatic applyStimulus(input logic [3:0] lbl, input bit use3);
    for (int i = 0; i < N; i++) input_values[i*DW +: DW] = cur_vec[i];
    label_in = lbl;
    if (use3) load3 = 1'b1; else load1 = 1'b1;
    @(negedge clk);
    load1 = 1'b0;
    load3 = 1'b0;
  endtask

  // Ready modes: 0 always high, 1 repeating 1,0,0,1, 2 random.
  task automatic stream_check(input int mode, input int passes, input logic [3:0] lbl,
                              input int inject_at, input int abort_at,
                              output int xfers, output int cycles, output int lasts);
    xfer_t e;
    bit    injected = 1'b0;
    int    total = N * passes;
    exp_q.delete();
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < N; i++)
        exp_q.push_back('{data: cur_vec[i], idx: i, last: (i == N-1), pass: p});
    xfers = 0; cycles = 0; lasts = 0;
    while (xfers < total && cycles < 4*total + 20) begin
      case (mode)
        0:       elem_ready = 1'b1;
        1:       elem_ready = (cycles % 4 == 0) || (cycles % 4 == 3);
        default: elem_ready = 1'($urandom_range(0, 1));
      endcase
      if (inject_at == xfers && !injected) begin
        input_values = ~input_values;
        label_in     = 4'd9;
        if (sel3) load3 = 1'b1; else load1 = 1'b1;
        injected = 1'b1;
      end else begin
        load1 = 1'b0;
        load3 = 1'b0;
      end
      if (abort_at == xfers) begin
        #2 rst_overall = 1'b1;
        #1;
        checkOutput("abort_valid", s_valid, 0);
        checkOutput("abort_busy",  s_busy,  0);
        checkOutput("abort_label", s_label, 0);
        return;
      end
      #1;
      checkOutput("valid", s_valid, 1);
      checkOutput("busy",  s_busy,  1);
      checkOutput("label", s_label, lbl);
      e = exp_q[0];
      checkOutput($sformatf("elem%0d", xfers), {s_data, s_index, s_last, s_pass},
                  {e.data, 6'(e.idx), e.last, 3'(e.pass)});
      if (s_valid && elem_ready) begin
        if (s_last) lasts++;
        void'(exp_q.pop_front());
        xfers++;
      end
      @(negedge clk);
      cycles++;
    end
    load1 = 1'b0;
    load3 = 1'b0;
    checkOutput("done_pulse", s_done,  1);
    checkOutput("end_valid",  s_valid, 0);
    checkOutput("end_busy",   s_busy,  0);
    checkOutput("end_index",  s_index, N-1);
  endtask

  row_t rows [5];
  int   xf, cy, ls, done_cnt;

  initial begin
    rows[0] = '{mode: 0, use3: 0, passes: 1, label: 4'd7, pattern: 0, exp_xfers: 64,  exp_lasts: 1, exp_final_pass: 0};
    rows[1] = '{mode: 1, use3: 0, passes: 1, label: 4'd7, pattern: 0, exp_xfers: 64,  exp_lasts: 1, exp_final_pass: 0};
    rows[2] = '{mode: 2, use3: 0, passes: 1, label: 4'd5, pattern: 1, exp_xfers: 64,  exp_lasts: 1, exp_final_pass: 0};
    rows[3] = '{mode: 0, use3: 1, passes: 3, label: 4'd2, pattern: 1, exp_xfers: 192, exp_lasts: 3, exp_final_pass: 2};
    rows[4] = '{mode: 1, use3: 1, passes: 3, label: 4'd9, pattern: 0, exp_xfers: 192, exp_lasts: 3, exp_final_pass: 2};

    rst_overall = 1'b1; rst_vals = 1'b0; load1 = 1'b0; load3 = 1'b0;
    elem_ready = 1'b0; input_values = '0; label_in = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      sel3 = k[0];
      #1;
      checkOutput("rst_outputs", {s_data, s_valid, s_last, s_done, s_busy, s_ovr, s_index, s_pass, s_label}, 0);
    end
    sel3 = 1'b0;
    rst_overall = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 5; r++) begin
      sel3 = rows[r].use3;
      fill_vec(rows[r].pattern);
      checkOutput("idle_valid", s_valid, 0);
      applyStimulus(rows[r].label, rows[r].use3);
      checkOutput("first_valid", s_valid, 1);
      stream_check(rows[r].mode, rows[r].passes, rows[r].label, -1, -1, xf, cy, ls);
      checkOutput("xfer_count", xf, rows[r].exp_xfers);
      checkOutput("last_count", ls, rows[r].exp_lasts);
      checkOutput("final_pass", s_pass, rows[r].exp_final_pass);
      if (rows[r].mode == 0) checkOutput("no_bubble", cy, rows[r].exp_xfers);
      @(negedge clk);
      checkOutput("done_once",  s_done,  0);
      checkOutput("label_hold", s_label, rows[r].label);
      checkOutput("no_overrun", s_ovr,   0);
    end
    sel3 = 1'b0;

    // Overrun: a second load mid-stream is ignored but flagged.
    fill_vec(1);
    applyStimulus(4'd3, 1'b0);
    stream_check(0, 1, 4'd3, 20, -1, xf, cy, ls);
    checkOutput("overrun_set", s_ovr, 1);
    @(negedge clk);
    checkOutput("overrun_sticky", s_ovr, 1);
    checkOutput("overrun_label",  s_label, 3);
    rst_vals = 1'b1;
    @(negedge clk);
    rst_vals = 1'b0;
    checkOutput("rst_vals_ovr",   s_ovr,   0);
    checkOutput("rst_vals_label", s_label, 0);
    checkOutput("rst_vals_index", s_index, 0);

    // Back-to-back: load on the vector_done cycle is accepted.
    fill_vec(0);
    applyStimulus(4'd7, 1'b0);
    stream_check(0, 1, 4'd7, -1, -1, xf, cy, ls);
    fill_vec(1);
    applyStimulus(4'd4, 1'b0);
    checkOutput("b2b_ovr",   s_ovr,   0);
    checkOutput("b2b_label", s_label, 4);
    checkOutput("b2b_valid", s_valid, 1);
    checkOutput("b2b_index", s_index, 0);
    stream_check(2, 1, 4'd4, -1, -1, xf, cy, ls);
    checkOutput("b2b_xfers", xf, 64);
    @(negedge clk);

    // Asynchronous abort mid-stream: no vector_done may follow.
    fill_vec(1);
    applyStimulus(4'd6, 1'b0);
    stream_check(0, 1, 4'd6, -1, 30, xf, cy, ls);
    @(negedge clk);
    rst_overall = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (s_done || s_valid) done_cnt++;
    end
    checkOutput("abort_no_done", done_cnt, 0);
    fill_vec(0);
    applyStimulus(4'd2, 1'b0);
    checkOutput("restart_index", s_index, 0);
    stream_check(1, 1, 4'd2, -1, -1, xf, cy, ls);
    checkOutput("restart_xfers", xf, 64);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
